// File: rtl/half_duplex_dir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : half_duplex_dir_ctrl_pkg
// Description : Shared state encoding and bus-buffer ctrl polarity for the
//               half-duplex direction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package half_duplex_dir_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GAP_TX  = 3'd1,
        TX      = 3'd2,
        TX_LAST = 3'd3,
        GAP_RX  = 3'd4
    } state_t;

    localparam logic DIR_DRIVE   = 1'b1;
    localparam logic DIR_RELEASE = 1'b0;

    // The local side owns the bus only while beats are being presented.
    function automatic logic drives_bus(input state_t s);
        return (s == TX) || (s == TX_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/half_duplex_dir_ctrl_turnaround_counter.sv
`default_nettype none
// ============================================================================
// Module      : half_duplex_dir_ctrl_turnaround_counter
// Description : Loadable down-counter timing the bus turnaround gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module half_duplex_dir_ctrl_turnaround_counter #(
    parameter int TURN = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int              CW       = 4;
    localparam logic [CW-1:0]   LOAD_VAL = CW'(TURN - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= LOAD_VAL;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/half_duplex_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : half_duplex_dir_ctrl
// Description : Direction sequencer for a shared bidirectional bus buffer with
//               turnaround gaps, bounded transmit bursts and receive priority.
// Revision    : 1.0 - initial release
// ============================================================================
module half_duplex_dir_ctrl
    import half_duplex_dir_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int TURN      = 2,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             rx_strobe,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic             dir,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
);

    localparam int            BW         = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    state_t           r_state;
    state_t           w_next;
    logic [BW-1:0]    r_burst_cnt;
    logic             r_dir;
    logic             r_busy;
    logic             r_rx_valid;
    logic [WIDTH-1:0] r_rx_data;
    logic [WIDTH-1:0] r_pad_out;
    logic             w_load;
    logic             w_capture;
    logic             w_accept;
    logic             w_gap_zero;
    logic             w_gap_dec;

    assign w_accept  = (r_state == TX) && tx_valid && (r_burst_cnt < BURST_MAX);
    assign w_gap_dec = (r_state == GAP_TX) || (r_state == GAP_RX);

    half_duplex_dir_ctrl_turnaround_counter #(
        .TURN (TURN)
    ) u_gap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .dec   (w_gap_dec),
        .zero  (w_gap_zero)
    );

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_strobe) begin
                    w_capture = 1'b1;
                end else if (tx_valid) begin
                    w_next = GAP_TX;
                    w_load = 1'b1;
                end
            end
            GAP_TX: begin
                // A receive before the first beat aborts the pending transmit.
                if (rx_strobe) begin
                    w_capture = 1'b1;
                    w_next    = IDLE;
                end else if (w_gap_zero) begin
                    w_next = TX;
                end
            end
            TX: begin
                // The cycle tx_valid drops already presents the final word.
                if (w_accept && (r_burst_cnt == BURST_LAST)) begin
                    w_next = TX_LAST;
                end else if (!tx_valid) begin
                    w_next = GAP_RX;
                    w_load = 1'b1;
                end
            end
            TX_LAST: begin
                w_next = GAP_RX;
                w_load = 1'b1;
            end
            GAP_RX: begin
                if (w_gap_zero) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are registered from the next state so dir changes align with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir       <= DIR_RELEASE;
            r_busy      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
            r_pad_out   <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_dir      <= drives_bus(w_next) ? DIR_DRIVE : DIR_RELEASE;
            r_busy     <= (w_next != IDLE);
            r_rx_valid <= w_capture;
            if (w_capture) begin
                r_rx_data <= pad_in;
            end
            if (w_accept) begin
                r_pad_out <= tx_data;
            end
            if (w_load && (w_next == GAP_TX)) begin
                r_burst_cnt <= '0;
            end else if (w_accept) begin
                r_burst_cnt <= r_burst_cnt + BW'(1);
            end
        end
    end

    assign tx_ready = w_accept;
    assign dir      = r_dir;
    assign busy     = r_busy;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign pad_out  = r_pad_out;

endmodule
`default_nettype wire

// File: tb/tb_half_duplex_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_half_duplex_dir_ctrl
// Description : Directed vector bench for half_duplex_dir_ctrl (TURN=2,
//               MAX_BURST=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_half_duplex_dir_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_strobe;
    logic [7:0] pad_in;
    logic [7:0] pad_out;
    logic       dir;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    half_duplex_dir_ctrl #(
        .WIDTH     (8),
        .TURN      (2),
        .MAX_BURST (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_strobe (rx_strobe),
        .pad_in    (pad_in),
        .pad_out   (pad_out),
        .dir       (dir),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tv;
        logic [7:0] td;
        logic       rs;
        logic [7:0] pi;
        logic       e_dir;
        logic       e_busy;
        logic       e_rdy;
        logic       e_rxv;
        logic [7:0] e_rxd;
        logic [7:0] e_po;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    endtask

    function automatic vec_t mk(input logic tv, input logic [7:0] td, input logic rs,
                                input logic [7:0] pi, input logic e_dir, input logic e_busy,
                                input logic e_rdy, input logic e_rxv, input logic [7:0] e_rxd,
                                input logic [7:0] e_po);
        vec_t v;
        v.tv = tv; v.td = td; v.rs = rs; v.pi = pi;
        v.e_dir = e_dir; v.e_busy = e_busy; v.e_rdy = e_rdy;
        v.e_rxv = e_rxv; v.e_rxd = e_rxd; v.e_po = e_po;
        return v;
    endfunction

    initial begin
        // Inputs during cycle i, and outputs expected during cycle i.
        //              tv  td     rs  pi     dir busy rdy rxv rxd    po
        vecs[0]  = mk(1, 8'h11, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00); // IDLE -> GAP_TX
        vecs[1]  = mk(1, 8'h11, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00);
        vecs[2]  = mk(1, 8'h11, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00);
        vecs[3]  = mk(1, 8'h11, 0, 8'h00, 1, 1, 1, 0, 8'h00, 8'h00); // TX beats
        vecs[4]  = mk(1, 8'h22, 0, 8'h00, 1, 1, 1, 0, 8'h00, 8'h11);
        vecs[5]  = mk(1, 8'h33, 0, 8'h00, 1, 1, 1, 0, 8'h00, 8'h22);
        vecs[6]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h33);
        vecs[7]  = mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h33); // GAP_RX
        vecs[8]  = mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h33);
        vecs[9]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h33);
        vecs[10] = mk(0, 8'h00, 1, 8'hA5, 0, 0, 0, 0, 8'h00, 8'h33); // rx in IDLE
        vecs[11] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 8'h33);
        vecs[12] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h33);
        vecs[13] = mk(1, 8'h44, 1, 8'h3C, 0, 0, 0, 0, 8'hA5, 8'h33); // rx wins over tx
        vecs[14] = mk(1, 8'h44, 0, 8'h00, 0, 0, 0, 1, 8'h3C, 8'h33);
        vecs[15] = mk(1, 8'h44, 1, 8'h5A, 0, 1, 0, 0, 8'h3C, 8'h33); // abort in GAP_TX
        vecs[16] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h5A, 8'h33);
        vecs[17] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h5A, 8'h33);
        vecs[18] = mk(1, 8'h66, 0, 8'h00, 0, 0, 0, 0, 8'h5A, 8'h33); // single beat
        vecs[19] = mk(1, 8'h66, 0, 8'h00, 0, 1, 0, 0, 8'h5A, 8'h33);
        vecs[20] = mk(1, 8'h66, 0, 8'h00, 0, 1, 0, 0, 8'h5A, 8'h33);
        vecs[21] = mk(1, 8'h66, 1, 8'hFF, 1, 1, 1, 0, 8'h5A, 8'h33); // rx ignored in TX
        vecs[22] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h5A, 8'h66);
        vecs[23] = mk(0, 8'h00, 1, 8'h77, 0, 1, 0, 0, 8'h5A, 8'h66); // rx ignored in GAP_RX
        vecs[24] = mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h5A, 8'h66);
        vecs[25] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h5A, 8'h66);
    end

    initial begin
        int b1, b2, gap, run1, phase, idx, pad_err, seen;
        logic       prev_acc;
        logic [7:0] prev_word;
        logic       done;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_strobe = 1'b0; pad_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_quiet", i, {28'd0, dir, busy, tx_ready, rx_valid}, 32'd0);
        end

        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1;
            check("dir", i, 32'(dir), 32'(vecs[i].e_dir));
            check("busy", i, 32'(busy), 32'(vecs[i].e_busy));
            check("rx_valid", i, 32'(rx_valid), 32'(vecs[i].e_rxv));
            check("rx_data", i, 32'(rx_data), 32'(vecs[i].e_rxd));
            check("pad_out", i, 32'(pad_out), 32'(vecs[i].e_po));
            tx_valid = vecs[i].tv; tx_data = vecs[i].td;
            rx_strobe = vecs[i].rs; pad_in = vecs[i].pi;
            #1;
            check("tx_ready", i, 32'(tx_ready), 32'(vecs[i].e_rdy));
        end

        // 20 words held valid: bursts of 16 then 4 separated by GAP_RX/IDLE/GAP_TX.
        b1 = 0; b2 = 0; gap = 0; run1 = 0; phase = 0; idx = 0; pad_err = 0;
        prev_acc = 1'b0; prev_word = '0; done = 1'b0;
        for (int cyc = 0; cyc < 120 && !done; cyc++) begin
            @(posedge clk); #1;
            if (prev_acc && (pad_out !== prev_word)) pad_err++;
            case (phase)
                0: if (dir) phase = 1;
                1: if (!dir) phase = 2;
                2: if (dir) phase = 3;
                3: if (!dir) phase = 4;
                default: ;
            endcase
            if (phase == 1) run1++;
            if (phase == 2) gap++;
            tx_valid = (idx < 20);
            tx_data  = 8'(idx) + 8'h80;
            #1;
            prev_acc  = tx_ready;
            prev_word = tx_data;
            if (tx_ready) begin
                if (phase == 1) b1++;
                else if (phase == 3) b2++;
                idx++;
            end
            if (phase == 4 && !busy) done = 1'b1;
        end
        tx_valid = 1'b0;
        check("burst_done", 0, 32'(done), 32'd1);
        check("burst1_beats", 0, 32'(b1), 32'd16);
        check("burst1_dir_cycles", 0, 32'(run1), 32'd17);
        check("burst_gap_cycles", 0, 32'(gap), 32'd5);
        check("burst2_beats", 0, 32'(b2), 32'd4);
        check("burst_total", 0, 32'(idx), 32'd20);
        check("burst_pad_out_errs", 0, 32'(pad_err), 32'd0);

        // Asynchronous reset in the middle of TX.
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_data = 8'h99;
        seen = 0;
        for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
            @(posedge clk); #1;
            if (dir) seen = 1;
        end
        check("mid_tx_reached", 0, 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dir", 0, 32'(dir), 32'd0);
        check("async_rst_busy", 0, 32'(busy), 32'd0);
        check("async_rst_pad_out", 0, 32'(pad_out), 32'd0);
        check("async_rst_tx_ready", 0, 32'(tx_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        tx_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_outputs", i,
                  {12'd0, pad_out, rx_data, dir, busy, tx_ready, rx_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
